// File: rtl/add_share_arb.sv
// add_share_arb: two requesters (0 = execute ALU, 1 = address/aux path) share one
// add_64bit adder. Round-robin arbitration on a valid/ready handshake. The sum,
// flags and owner id go into a one-entry output register.
// Optional build macro: ADD_SHARE_ARB_CC_EN adds the cc condition-code register/port,
// which tracks the flags of consumed requester-0 results.

module add_64bit (
    input  logic signed [63:0] a_i,
    input  logic signed [63:0] b_i,
    output logic signed [63:0] sum_o,
    output logic        [2:0]  cf_o
);
    // Two's complement add; flags are {ZF, SF, OF}, no carry-out is produced.
    assign sum_o   = a_i + b_i;
    assign cf_o[2] = (sum_o == 64'sd0);
    assign cf_o[1] = sum_o[63];
    assign cf_o[0] = (a_i[63] == b_i[63]) && (sum_o[63] != a_i[63]);
endmodule

module add_share_arb #(
    parameter int WIDTH = 64,   // fixed by the add_64bit instance; only 64 is supported
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic signed [WIDTH-1:0] req0_a,
    input  logic signed [WIDTH-1:0] req0_b,
    input  logic signed [WIDTH-1:0] req1_a,
    input  logic signed [WIDTH-1:0] req1_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic signed [WIDTH-1:0] rsp_sum,
    output logic [2:0]              rsp_cf,
    output logic [CNT_W-1:0]        op_count
`ifdef ADD_SHARE_ARB_CC_EN
    ,
    output logic [2:0]              cc
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic                    last_grant_q;
    logic                    rsp_id_q;
    logic signed [WIDTH-1:0] rsp_sum_q;
    logic [2:0]              rsp_cf_q;
    logic [CNT_W-1:0]        op_count_q;

    logic                    can_accept;
    logic                    grant_any;
    logic                    grant_id;
    logic                    consume;
    logic signed [WIDTH-1:0] add_a, add_b, add_sum;
    logic [2:0]              add_cf;

    assign consume = (state_q == FULL) && rsp_ready;

    // Round-robin arbiter: a lone requester wins; on contention the one not granted last time wins.
    always_comb begin
        can_accept = (state_q == EMPTY) || rsp_ready;
        grant_any  = 1'b0;
        grant_id   = 1'b0;
        if (can_accept) begin
            unique case (req_valid)
                2'b01:   begin grant_any = 1'b1; grant_id = 1'b0;          end
                2'b10:   begin grant_any = 1'b1; grant_id = 1'b1;          end
                2'b11:   begin grant_any = 1'b1; grant_id = ~last_grant_q; end
                default: begin grant_any = 1'b0; grant_id = 1'b0;          end
            endcase
        end
    end

    // Operand mux in front of the shared adder.
    always_comb begin
        add_a = grant_id ? req1_a : req0_a;
        add_b = grant_id ? req1_b : req0_b;
    end

    add_64bit u_add (
        .a_i   (add_a),
        .b_i   (add_b),
        .sum_o (add_sum),
        .cf_o  (add_cf)
    );

    // Output-stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Next state: fill on grant, drain when consumed without a replacement, otherwise hold.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (grant_any)               state_d = FULL;
            FULL:    if (rsp_ready && !grant_any) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Handshake outputs derived from state and the arbiter decision.
    always_comb begin
        rsp_valid = (state_q == FULL);
        req_ready = 2'b00;
        if (grant_any) req_ready[grant_id] = 1'b1;
    end

    // Result register and round-robin pointer; both load only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_cf_q     <= 3'b000;
        end else if (grant_any) begin
            last_grant_q <= grant_id;
            rsp_id_q     <= grant_id;
            rsp_sum_q    <= add_sum;
            rsp_cf_q     <= add_cf;
        end
    end

    // Completed-operation counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       op_count_q <= '0;
        else if (consume) op_count_q <= op_count_q + CNT_ONE;
    end

`ifdef ADD_SHARE_ARB_CC_EN
    logic [2:0] cc_q;

    // Architectural condition codes follow only consumed ALU (requester 0) results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    cc_q <= 3'b000;
        else if (consume && !rsp_id_q) cc_q <= rsp_cf_q;
    end

    assign cc = cc_q;
`endif

    assign rsp_id   = rsp_id_q;
    assign rsp_sum  = rsp_sum_q;
    assign rsp_cf   = rsp_cf_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_add_share_arb.sv
// Testbench for add_share_arb: table of directed single-cycle vectors, hand-written
// stall and asynchronous-reset sequences, then randomized traffic against a
// behavioural model. Honors ADD_SHARE_ARB_CC_EN when defined.

module tb_add_share_arb;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic signed [63:0] req0_a, req0_b, req1_a, req1_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic signed [63:0] rsp_sum;
    logic [2:0]         rsp_cf;
    logic [31:0]        op_count;
`ifdef ADD_SHARE_ARB_CC_EN
    logic [2:0]         cc;
`endif

    add_share_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cf    (rsp_cf),
        .op_count  (op_count)
`ifdef ADD_SHARE_ARB_CC_EN
        ,
        .cc        (cc)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    localparam logic signed [64:0] MAXV = 65'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [64:0] MINV = -65'sh0_8000_0000_0000_0000;

    // Reference: exact sum in 65 bits, overflow means it does not fit in 64 signed bits.
    function automatic logic [66:0] ref_add(input logic signed [63:0] a, input logic signed [63:0] b);
        logic signed [64:0] w;
        logic [63:0]        s;
        logic               ovf;
        w   = 65'(a) + 65'(b);
        s   = w[63:0];
        ovf = (w > MAXV) || (w < MINV);
        return {s == 64'd0, s[63], ovf, s};
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 5))
            0:       return 64'h7FFF_FFFF_FFFF_FFFF;
            1:       return 64'h8000_0000_0000_0000;
            2:       return 64'h0;
            3:       return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    typedef struct {
        logic [1:0]  v;
        logic [63:0] a0, b0, a1, b1;
        logic [1:0]  rdy;
        logic        id;
        logic [63:0] sum;
        logic [2:0]  cf;
    } vec_t;

    vec_t tbl[8];

    // behavioural model state
    logic        m_valid, m_id, m_last;
    logic [63:0] m_sum;
    logic [2:0]  m_cf;
    logic [31:0] m_count;
    logic [2:0]  m_cc;
    logic [2:0]  exp_cc;

    initial begin
        tbl[0] = '{2'b01, 64'd11, 64'd4, 64'd0, 64'd0, 2'b01, 1'b0, 64'd15, 3'b000};
        tbl[1] = '{2'b01, -64'sd11, 64'd4, 64'd0, 64'd0, 2'b01, 1'b0, -64'sd7, 3'b010};
        tbl[2] = '{2'b01, 64'd11, -64'sd11, 64'd0, 64'd0, 2'b01, 1'b0, 64'd0, 3'b100};
        tbl[3] = '{2'b10, 64'd0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b10, 1'b1,
                   64'h8000_0000_0000_0000, 3'b011};
        tbl[4] = '{2'b11, 64'd1, 64'd2, 64'd3, 64'd4, 2'b01, 1'b0, 64'd3, 3'b000};
        tbl[5] = '{2'b11, 64'd1, 64'd2, 64'd3, 64'd4, 2'b10, 1'b1, 64'd7, 3'b000};
        tbl[6] = '{2'b10, 64'd0, 64'd0, -64'sd1, -64'sd1, 2'b10, 1'b1, -64'sd2, 3'b010};
        tbl[7] = '{2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 64'd0,
                   2'b01, 1'b0, 64'd0, 3'b101};

        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset rsp_id", 64'(rsp_id), 64'd0);
        chk("reset rsp_sum", rsp_sum, 64'd0);
        chk("reset rsp_cf", 64'(rsp_cf), 64'd0);
        chk("reset op_count", 64'(op_count), 64'd0);
        chk("reset first contention", 64'(req_ready), 64'b01);
`ifdef ADD_SHARE_ARB_CC_EN
        chk("reset cc", 64'(cc), 64'd0);
`endif
        rst_n = 1'b1;

        // directed vectors, one accepted and consumed per cycle
        exp_cc = 3'b000;
        for (int k = 0; k < 8; k++) begin
            req_valid = tbl[k].v;
            req0_a = tbl[k].a0; req0_b = tbl[k].b0;
            req1_a = tbl[k].a1; req1_b = tbl[k].b1;
            rsp_ready = 1'b1;
            #1;
            chk($sformatf("vec%0d req_ready", k), 64'(req_ready), 64'(tbl[k].rdy));
            @(posedge clk); #1;
            if (k > 0 && tbl[k-1].id == 1'b0) exp_cc = tbl[k-1].cf;
            chk($sformatf("vec%0d rsp_valid", k), 64'(rsp_valid), 64'd1);
            chk($sformatf("vec%0d rsp_id", k), 64'(rsp_id), 64'(tbl[k].id));
            chk($sformatf("vec%0d rsp_sum", k), rsp_sum, tbl[k].sum);
            chk($sformatf("vec%0d rsp_cf", k), 64'(rsp_cf), 64'(tbl[k].cf));
            chk($sformatf("vec%0d op_count", k), 64'(op_count), 64'(k));
`ifdef ADD_SHARE_ARB_CC_EN
            chk($sformatf("vec%0d cc", k), 64'(cc), 64'(exp_cc));
`endif
        end

        // stall while FULL: no accepts, held result stable
        rsp_ready = 1'b0; req_valid = 2'b01; req0_a = 64'd5; req0_b = 64'd6;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall req_ready", 64'(req_ready), 64'b00);
            @(posedge clk); #1;
            chk("stall rsp_valid", 64'(rsp_valid), 64'd1);
            chk("stall rsp_sum", rsp_sum, tbl[7].sum);
            chk("stall rsp_cf", 64'(rsp_cf), 64'(tbl[7].cf));
            chk("stall rsp_id", 64'(rsp_id), 64'(tbl[7].id));
            chk("stall op_count", 64'(op_count), 64'd7);
        end
        rsp_ready = 1'b1;
        #1;
        chk("unstall req_ready", 64'(req_ready), 64'b01);
        @(posedge clk); #1;
        chk("unstall rsp_sum", rsp_sum, 64'd11);
        chk("unstall rsp_valid", 64'(rsp_valid), 64'd1);
        chk("unstall op_count", 64'(op_count), 64'd8);
`ifdef ADD_SHARE_ARB_CC_EN
        chk("unstall cc", 64'(cc), 64'(tbl[7].cf));
`endif

        // asynchronous reset while FULL
        rsp_ready = 1'b0; req_valid = 2'b00;
        #2; rst_n = 1'b0; #1;
        chk("async rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("async rst op_count", 64'(op_count), 64'd0);
        chk("async rst rsp_sum", rsp_sum, 64'd0);
`ifdef ADD_SHARE_ARB_CC_EN
        chk("async rst cc", 64'(cc), 64'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 2'b11; req0_a = 64'd100; req0_b = 64'd1; req1_a = 64'd200; req1_b = 64'd2;
        #1;
        chk("post rst contention", 64'(req_ready), 64'b01);
        @(posedge clk); #1;
        chk("post rst rsp_id", 64'(rsp_id), 64'd0);
        chk("post rst rsp_sum", rsp_sum, 64'd101);
        rsp_ready = 1'b1;
        #1;
        chk("post rst alternate", 64'(req_ready), 64'b10);
        @(posedge clk); #1;
        chk("post rst rsp_id 2", 64'(rsp_id), 64'd1);
        chk("post rst rsp_sum 2", rsp_sum, 64'd202);
        chk("post rst op_count", 64'(op_count), 64'd1);

        // randomized traffic against the behavioural model
        req_valid = 2'b00; rsp_ready = 1'b0;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        m_valid = 1'b0; m_id = 1'b0; m_last = 1'b1; m_sum = '0; m_cf = '0;
        m_count = '0; m_cc = '0;
        begin
            logic [1:0]  pend;
            logic [1:0]  exp_rdy;
            logic [66:0] r;
            logic        can, g, gid;
            pend = 2'b00;
            for (int c = 0; c < 400; c++) begin
                if (!pend[0]) begin
                    req_valid[0] = ($urandom_range(0, 2) != 0);
                    req0_a = rand64(); req0_b = rand64();
                end
                if (!pend[1]) begin
                    req_valid[1] = ($urandom_range(0, 2) != 0);
                    req1_a = rand64(); req1_b = rand64();
                end
                rsp_ready = ($urandom_range(0, 3) != 0);

                can = !m_valid || rsp_ready;
                g   = can && (req_valid != 2'b00);
                if (req_valid == 2'b11) gid = !m_last;
                else                    gid = req_valid[1];
                exp_rdy = 2'b00;
                if (g) exp_rdy[gid] = 1'b1;
                #1;
                chk("rand req_ready", 64'(req_ready), 64'(exp_rdy));
                pend = req_valid & ~exp_rdy;

                if (m_valid && rsp_ready) begin
                    m_count = m_count + 1;
                    if (!m_id) m_cc = m_cf;
                end
                if (g) begin
                    r = gid ? ref_add(req1_a, req1_b) : ref_add(req0_a, req0_b);
                    m_valid = 1'b1; m_id = gid; m_last = gid;
                    m_sum = r[63:0]; m_cf = r[66:64];
                end else if (rsp_ready) begin
                    m_valid = 1'b0;
                end

                @(posedge clk); #1;
                chk("rand rsp_valid", 64'(rsp_valid), 64'(m_valid));
                chk("rand op_count", 64'(op_count), 64'(m_count));
                if (m_valid) begin
                    chk("rand rsp_id", 64'(rsp_id), 64'(m_id));
                    chk("rand rsp_sum", rsp_sum, m_sum);
                    chk("rand rsp_cf", 64'(rsp_cf), 64'(m_cf));
                end
`ifdef ADD_SHARE_ARB_CC_EN
                chk("rand cc", 64'(cc), 64'(m_cc));
`endif
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
